// File: rtl/control_unit.sv
// Multicycle fetch/decode/sequencing stage: 3 cycles per ALU op/jump/st, 4 per ld, plus one per memory wait.
// Fetch and data requests hold stable until acked; reset drops them combinationally in the same cycle.
module control_unit (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_run,
   output logic       o_imem_req,
   output logic [3:0] o_imem_addr,
   input  logic       i_imem_ack,
   input  logic [7:0] i_imem_data,
   output logic       o_dmem_req,
   output logic       o_dmem_we,
   output logic [3:0] o_dmem_addr,
   output logic [3:0] o_dmem_wdata,
   input  logic       i_dmem_ack,
   input  logic [3:0] i_dmem_rdata,
   output logic [3:0] o_alu_op,
   output logic [3:0] o_alu_rx,
   output logic [3:0] o_alu_ry,
   output logic [3:0] o_alu_mem,
   input  logic [3:0] i_alu_out,
   input  logic       i_alu_z,
   input  logic       i_alu_n,
   output logic [3:0] o_pc,
   output logic       o_retire,
   output logic       o_busy
);

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

   localparam logic [3:0] OP_LD = 4'b1110;
   localparam logic [3:0] OP_ST = 4'b1111;

   state_t     r_state;
   logic [7:0] r_ir;
   logic [3:0] r_pc;
   logic [3:0] r_rf [4];
   logic       r_z;
   logic       r_n;
   logic [3:0] r_mdr;
   logic       r_ireq_pend;

   logic [3:0] w_op;
   logic [1:0] w_rx;
   logic [1:0] w_ry;
   logic [3:0] w_pc_inc;
   logic       w_is_st;
   logic       w_imem_req;
   logic       w_dmem_req;
   logic       w_taken;
   logic       w_writes_rf;

   assign w_op        = r_ir[7:4];
   assign w_rx        = r_ir[3:2];
   assign w_ry        = r_ir[1:0];
   assign w_pc_inc    = r_pc + 4'd1;
   assign w_is_st     = (w_op == OP_ST);
   assign w_writes_rf = (w_op >= 4'd1) && (w_op <= 4'd8);

   // A request, once raised, stays up through run dropping until the ack arrives.
   assign w_imem_req = !i_rst && (r_state == S_FETCH) && (i_run || r_ireq_pend);
   assign w_dmem_req = !i_rst && (r_state == S_MEM);

   always_comb begin
      w_taken = 1'b0;
      case (w_op)
         4'b1001: w_taken = 1'b1;
         4'b1010: w_taken = r_z;
         4'b1011: w_taken = !r_z;
         4'b1100: w_taken = r_n;
         4'b1101: w_taken = !r_n;
         default: w_taken = 1'b0;
      endcase
   end

   always_comb begin
      o_alu_op = 4'b0000;
      if (!i_rst && r_state == S_EXEC)
         o_alu_op = w_op;
      else if (!i_rst && r_state == S_WB)
         o_alu_op = OP_LD;
   end

   assign o_imem_req   = w_imem_req;
   assign o_imem_addr  = r_pc;
   assign o_dmem_req   = w_dmem_req;
   assign o_dmem_we    = w_dmem_req && w_is_st;
   assign o_dmem_addr  = r_rf[w_ry];
   assign o_dmem_wdata = r_rf[w_rx];
   assign o_alu_rx     = r_rf[w_rx];
   assign o_alu_ry     = r_rf[w_ry];
   assign o_alu_mem    = r_mdr;
   assign o_pc         = i_rst ? 4'd0 : r_pc;
   assign o_retire     = !i_rst && ((r_state == S_EXEC) || (r_state == S_WB) ||
                                    (w_dmem_req && i_dmem_ack && w_is_st));
   assign o_busy       = (r_state != S_FETCH) || w_imem_req;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_FETCH;
         r_ir        <= 8'd0;
         r_pc        <= 4'd0;
         r_z         <= 1'b0;
         r_n         <= 1'b0;
         r_mdr       <= 4'd0;
         r_ireq_pend <= 1'b0;
         for (int i = 0; i < 4; i++) r_rf[i] <= 4'd0;
      end else begin
         case (r_state)
            S_FETCH: begin
               if (w_imem_req) begin
                  if (i_imem_ack) begin
                     r_ir        <= i_imem_data;
                     r_ireq_pend <= 1'b0;
                     r_state     <= S_DECODE;
                  end else begin
                     r_ireq_pend <= 1'b1;
                  end
               end
            end
            S_DECODE: begin
               r_state <= (w_op == OP_LD || w_op == OP_ST) ? S_MEM : S_EXEC;
            end
            S_EXEC: begin
               if (w_writes_rf) begin
                  r_rf[w_rx] <= i_alu_out;
                  r_z        <= i_alu_z;
                  r_n        <= i_alu_n;
               end
               r_pc    <= w_taken ? i_alu_out : w_pc_inc;
               r_state <= S_FETCH;
            end
            S_MEM: begin
               if (i_dmem_ack) begin
                  if (w_is_st) begin
                     r_pc    <= w_pc_inc;
                     r_state <= S_FETCH;
                  end else begin
                     r_mdr   <= i_dmem_rdata;
                     r_state <= S_WB;
                  end
               end
            end
            S_WB: begin
               r_rf[w_rx] <= i_alu_out;
               r_z        <= i_alu_z;
               r_n        <= i_alu_n;
               r_pc       <= w_pc_inc;
               r_state    <= S_FETCH;
            end
            default: r_state <= S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit with a small behavioural ALU and handshake-driven memories.
module tb_control_unit;

   logic       i_clk;
   logic       i_rst;
   logic       i_run;
   logic       o_imem_req;
   logic [3:0] o_imem_addr;
   logic       i_imem_ack;
   logic [7:0] i_imem_data;
   logic       o_dmem_req;
   logic       o_dmem_we;
   logic [3:0] o_dmem_addr;
   logic [3:0] o_dmem_wdata;
   logic       i_dmem_ack;
   logic [3:0] i_dmem_rdata;
   logic [3:0] o_alu_op;
   logic [3:0] o_alu_rx;
   logic [3:0] o_alu_ry;
   logic [3:0] o_alu_mem;
   logic [3:0] i_alu_out;
   logic       i_alu_z;
   logic       i_alu_n;
   logic [3:0] o_pc;
   logic       o_retire;
   logic       o_busy;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [3:0] exp_pc;
   int         m_cyc;
   logic [3:0] m_addr;
   logic [3:0] m_wdata;
   logic       m_we;

   control_unit dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_run(i_run),
      .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
      .i_imem_ack(i_imem_ack), .i_imem_data(i_imem_data),
      .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
      .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata),
      .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata),
      .o_alu_op(o_alu_op), .o_alu_rx(o_alu_rx), .o_alu_ry(o_alu_ry), .o_alu_mem(o_alu_mem),
      .i_alu_out(i_alu_out), .i_alu_z(i_alu_z), .i_alu_n(i_alu_n),
      .o_pc(o_pc), .o_retire(o_retire), .o_busy(o_busy)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Reference ALU: add/sub for arithmetic, jumps pass rx through, ld passes mem through.
   always_comb begin
      case (o_alu_op)
         4'b0001: i_alu_out = o_alu_rx + o_alu_ry;
         4'b0010: i_alu_out = o_alu_rx - o_alu_ry;
         4'b1110: i_alu_out = o_alu_mem;
         default: i_alu_out = o_alu_rx;
      endcase
      i_alu_z = (i_alu_out == 4'd0);
      i_alu_n = i_alu_out[3];
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Entered just after a rising edge with the DUT in FETCH; leaves just after the retire edge.
   task automatic run_instr(input logic [7:0] ins, input int iw, input int dw, input logic [3:0] rd,
                            output int cyc, output logic hold_ok, output logic [3:0] rop);
      bit done;
      done    = 1'b0;
      cyc     = 0;
      hold_ok = 1'b1;
      rop     = 4'd0;
      m_cyc   = 0;
      i_run   = 1'b1;
      #1;
      for (int k = 0; k < iw; k++) begin
         if (o_imem_req !== 1'b1 || o_imem_addr !== exp_pc) hold_ok = 1'b0;
         @(posedge i_clk); #1;
         i_run = 1'b0;
         #1;
         cyc++;
      end
      i_imem_ack  = 1'b1;
      i_imem_data = ins;
      #1;
      if (o_imem_req !== 1'b1 || o_imem_addr !== exp_pc) hold_ok = 1'b0;
      @(posedge i_clk); #1;
      i_imem_ack = 1'b0;
      i_run      = 1'b0;
      cyc++;
      for (int k = 0; k < 20 && !done; k++) begin
         i_dmem_ack   = (o_dmem_req === 1'b1) && (m_cyc >= dw);
         i_dmem_rdata = rd;
         #1;
         if (o_dmem_req === 1'b1) begin
            if (m_cyc == 0) begin
               m_addr  = o_dmem_addr;
               m_wdata = o_dmem_wdata;
               m_we    = o_dmem_we;
            end else if (o_dmem_addr !== m_addr || o_dmem_wdata !== m_wdata || o_dmem_we !== m_we) begin
               hold_ok = 1'b0;
            end
            m_cyc++;
         end
         if (o_retire === 1'b1) begin
            rop  = o_alu_op;
            done = 1'b1;
         end
         cyc++;
         @(posedge i_clk); #1;
         i_dmem_ack = 1'b0;
      end
   endtask

   task automatic step(input string tag, input logic [7:0] ins, input int iw, input int dw,
                       input logic [3:0] rd, input int ecyc, input logic [3:0] epc,
                       input logic [3:0] erx, input logic [3:0] eop);
      int         cyc;
      logic       hold_ok;
      logic [3:0] rop;
      run_instr(ins, iw, dw, rd, cyc, hold_ok, rop);
      chk({tag, "_cycles"}, cyc, ecyc);
      chk({tag, "_pc"}, o_pc, epc);
      chk({tag, "_rx"}, o_alu_rx, erx);
      chk({tag, "_retire_op"}, rop, eop);
      chk({tag, "_hold"}, hold_ok, 1'b1);
      exp_pc = epc;
   endtask

   initial begin
      i_rst = 1'b1; i_run = 1'b0; i_imem_ack = 1'b0; i_imem_data = 8'd0;
      i_dmem_ack = 1'b0; i_dmem_rdata = 4'd0; exp_pc = 4'd0;
      m_cyc = 0; m_addr = 4'd0; m_wdata = 4'd0; m_we = 1'b0;

      repeat (2) @(posedge i_clk);
      #1;
      chk("rst_pc", o_pc, 4'd0);
      chk("rst_imem_req", o_imem_req, 1'b0);
      chk("rst_dmem_req", o_dmem_req, 1'b0);
      chk("rst_retire", o_retire, 1'b0);
      chk("rst_alu_op", o_alu_op, 4'd0);
      i_rst = 1'b0;
      #1;
      chk("idle_busy", o_busy, 1'b0);
      chk("idle_regs", {o_alu_rx, o_alu_ry, o_alu_mem}, 12'd0);

      // Stray fetch ack with no request must not load IR or leave FETCH.
      i_imem_ack = 1'b1; i_imem_data = 8'hFF;
      @(posedge i_clk); #1;
      i_imem_ack = 1'b0;
      #1;
      chk("stray_ack_busy", o_busy, 1'b0);
      chk("stray_ack_ir", o_alu_rx, 4'd0);

      i_run = 1'b1;
      #1;
      chk("run_imem_req", o_imem_req, 1'b1);
      chk("run_imem_addr", o_imem_addr, 4'd0);

      //    tag        ins    iw dw rd     cyc pc     rx     retire-op
      step("ld_r0",   8'hE0, 0, 0, 4'h7, 4, 4'h1, 4'h7, 4'hE);
      step("ld_r1",   8'hE4, 0, 0, 4'h9, 4, 4'h2, 4'h9, 4'hE);
      step("ld_r2",   8'hE8, 0, 1, 4'hC, 5, 4'h3, 4'hC, 4'hE);
      step("ld_r3",   8'hEC, 0, 0, 4'h1, 4, 4'h4, 4'h1, 4'hE);
      step("add01",   8'h11, 1, 0, 4'h0, 4, 4'h5, 4'h0, 4'h1);
      step("jz_t",    8'hA8, 0, 0, 4'h0, 3, 4'hC, 4'hC, 4'hA);
      step("add33",   8'h1F, 0, 0, 4'h0, 3, 4'hD, 4'h2, 4'h1);
      step("jz_nt",   8'hA8, 0, 0, 4'h0, 3, 4'hE, 4'hC, 4'hA);
      step("jnz_t",   8'hB8, 0, 0, 4'h0, 3, 4'hC, 4'hC, 4'hB);
      step("add00a",  8'h10, 0, 0, 4'h0, 3, 4'hD, 4'h0, 4'h1);
      step("jnz_nt",  8'hB8, 0, 0, 4'h0, 3, 4'hE, 4'hC, 4'hB);
      step("ld_neg1", 8'hE6, 0, 0, 4'h8, 4, 4'hF, 4'h8, 4'hE);
      step("jn_t",    8'hC8, 0, 0, 4'h0, 3, 4'hC, 4'hC, 4'hC);
      step("add00b",  8'h10, 0, 0, 4'h0, 3, 4'hD, 4'h0, 4'h1);
      step("jn_nt",   8'hC8, 0, 0, 4'h0, 3, 4'hE, 4'hC, 4'hC);
      step("jnn_t",   8'hD8, 0, 0, 4'h0, 3, 4'hC, 4'hC, 4'hD);
      step("ld_neg2", 8'hE6, 0, 0, 4'h8, 4, 4'hD, 4'h8, 4'hE);
      step("jnn_nt",  8'hD8, 0, 0, 4'h0, 3, 4'hE, 4'hC, 4'hD);
      step("ld_r1_5", 8'hE6, 0, 0, 4'h5, 4, 4'hF, 4'h5, 4'hE);
      step("nop_wrap",8'h00, 0, 0, 4'h0, 3, 4'h0, 4'h0, 4'h0);
      step("ld_r2_3", 8'hEA, 0, 0, 4'h3, 4, 4'h1, 4'h3, 4'hE);
      step("st_wait", 8'hF6, 0, 2, 4'h0, 5, 4'h2, 4'h5, 4'h0);
      chk("st_mem_cycles", m_cyc, 3);
      chk("st_addr", m_addr, 4'h3);
      chk("st_wdata", m_wdata, 4'h5);
      chk("st_we", m_we, 1'b1);
      step("ld_r0_8", 8'hE2, 0, 0, 4'h8, 4, 4'h3, 4'h8, 4'hE);
      step("jz_z0",   8'hA0, 0, 0, 4'h0, 3, 4'h4, 4'h8, 4'hA);
      step("jn_n1",   8'hC0, 0, 0, 4'h0, 3, 4'h8, 4'h8, 4'hC);

      // Reset during a stalled store.
      i_run = 1'b1; i_imem_ack = 1'b1; i_imem_data = 8'hF6;
      @(posedge i_clk); #1;
      i_imem_ack = 1'b0; i_run = 1'b0;
      @(posedge i_clk); #1;
      chk("mid_dmem_req_pre", o_dmem_req, 1'b1);
      i_rst = 1'b1;
      #1;
      chk("mid_dmem_req_drop", o_dmem_req, 1'b0);
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      #1;
      chk("mid_busy", o_busy, 1'b0);
      chk("mid_pc", o_pc, 4'd0);
      chk("mid_dmem_req_after", o_dmem_req, 1'b0);
      i_dmem_ack = 1'b1; i_dmem_rdata = 4'hA;
      #1;
      chk("mid_late_ack_retire", o_retire, 1'b0);
      @(posedge i_clk); #1;
      i_dmem_ack = 1'b0;
      #1;
      chk("mid_late_ack_busy", o_busy, 1'b0);
      chk("mid_late_ack_pc", o_pc, 4'd0);
      chk("mid_regs", {o_alu_rx, o_alu_ry, o_alu_mem}, 12'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/control_unit.md
# control_unit

Multicycle fetch/decode/sequencing stage of the 4-bit CPU. Fetches 8-bit instructions from instruction memory, holds the 4×4-bit register file, PC and Z/N flags, drives the ALU's `op`/`rx`/`ry`/`mem` inputs and consumes its `out`/`z`/`n`. It also performs data-memory load/store handshakes and resolves conditional jumps.

## Interface
- No parameters. Data width is 4, register count is 4, and instruction width is 8. These are fixed.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `run` in 1: permits starting a new fetch.
- `imem_req` out 1: instruction fetch request.
- `imem_addr` out 4: fetch address (= PC).
- `imem_ack` in 1: fetch complete; `imem_data` is valid this cycle.
- `imem_data` in 8: instruction. Fields are `[7:4]` op, `[3:2]` rx select, `[1:0]` ry select.
- `dmem_req` out 1: data access request.
- `dmem_we` out 1: 1 = store, 0 = load.
- `dmem_addr` out 4: the value of register ry.
- `dmem_wdata` out 4: the value of register rx.
- `dmem_ack` in 1: access complete; `dmem_rdata` is valid this cycle on loads.
- `dmem_rdata` in 4: load data.
- `alu_op`, `alu_rx`, `alu_ry`, `alu_mem` out 4 each: ALU operands.
- `alu_out` in 4, `alu_z` in 1, `alu_n` in 1: ALU results.
- `pc` out 4: current PC.
- `retire` out 1: one-cycle pulse on the final cycle of each instruction.
- `busy` out 1: high whenever state ≠ FETCH, or `imem_req` is high.

## Operation
- **Registers:** IR (8), PC (4), R0–R3 (4 each), Z, N, MDR (4), state.
- **Reset state:** all registers are 0 and state = FETCH.
- **Outputs during reset:** `imem_req`, `dmem_req`, `dmem_we` and `retire` are 0. `alu_op` is 0 (nop). `pc` is 0.
- **FETCH:**
  - If `run`=1, or a request is already pending, assert `imem_req` with `imem_addr`=PC.
  - Once asserted, `imem_req` and `imem_addr` hold until `imem_ack`. `run` dropping does not cancel the request.
  - On `imem_ack`, IR ← `imem_data` and go to DECODE.
  - `imem_ack` without `imem_req` is ignored.
- **DECODE:** one cycle, no side effects. Branch on the op field:
  - 1110 (ld) → MEM with `dmem_we`=0.
  - 1111 (st) → MEM with `dmem_we`=1.
  - All other ops → EXEC.
- **EXEC:** one cycle. Drive `alu_op`=IR op, `alu_rx`=R[rx], `alu_ry`=R[ry], `alu_mem`=MDR.
  - **Ops 0001–1000:** R[rx] ← `alu_out`, Z ← `alu_z`, N ← `alu_n`, PC ← PC+1.
  - **Op 0000 (nop):** no register or flag write; PC ← PC+1.
  - **Jumps** use target = `alu_out` (= R[rx]). Flags are unchanged. The jump is taken when:
    - 1001 jmp: always;
    - 1010 jz: Z=1;
    - 1011 jnz: Z=0;
    - 1100 jn: N=1;
    - 1101 jnn: N=0.
  - If taken, PC ← target; otherwise PC ← PC+1.
  - Go to FETCH with `retire`=1.
- **MEM:**
  - Assert `dmem_req` with `dmem_addr`=R[ry] and `dmem_wdata`=R[rx]. Hold them stable until `dmem_ack`.
  - On ack for st: PC ← PC+1, `retire`=1, go to FETCH. Flags are unchanged.
  - On ack for ld: MDR ← `dmem_rdata`, go to WB.
- **WB (ld only):** drive `alu_op`=1110 and `alu_mem`=MDR. R[rx] ← `alu_out`, Z ← `alu_z`, N ← `alu_n`, PC ← PC+1, `retire`=1, go to FETCH.
- **Outside EXEC/WB:** `alu_op`=0000, and `alu_rx`/`alu_ry`/`alu_mem` still reflect IR and MDR.
- **Width rules:**
  - PC increment is modulo 16; PC 15 wraps to 0.
  - Register writes are the 4-bit ALU result with no carry.
  - rx = ry is legal: a read-before-write value is used.
- **Reset mid-operation:** a reset in any state returns to the reset state on the next edge. Outstanding `imem_req` and `dmem_req` drop in that same cycle, and any late ack is ignored.

## Timing
- **Zero-wait memory** (ack in the same cycle as req):
  - ALU op, nop and jump: 3 cycles (FETCH, DECODE, EXEC).
  - st: 3 cycles (FETCH, DECODE, MEM).
  - ld: 4 cycles (FETCH, DECODE, MEM, WB).
- Each memory wait cycle adds one cycle to FETCH or MEM.
- `retire` is asserted only in the last cycle of the instruction. The PC, register and flag updates become visible on the following edge, which is the same cycle the next FETCH begins.
- A new `imem_req` can assert in the cycle immediately after `retire`.
- Flags read by a jump are those committed by earlier instructions, never by the jump itself.

## Test plan
- **Reset and idle:** assert `rst` for 2 cycles with `run`=0 → `pc`=0, `imem_req`=0, `busy`=0, all registers 0. Raise `run` → `imem_req`=1 with `imem_addr`=0.
- **ALU op and flags:** program 0x1_0_1 (add R0,R1) with R0=0x7 and R1=0x9 preloaded via ld. Expect R0=0x0, Z=1, N=0, `retire` 3 cycles after fetch start, PC+1.
- **Conditional jump:** after Z=1, execute jz R2 with R2=0xC → PC=0xC. Clear Z with a nonzero add, repeat → PC+1. Repeat the pair with jnz, jn and jnn.
- **Load/store with waits:** st R1→[R2] with R1=0x5 and R2=0x3, ack delayed 2 cycles → `dmem_req`, `dmem_we`=1, `dmem_addr`=3 and `dmem_wdata`=5 held all 3 cycles. Then ld R0←[R2] returning 0x8 → R0=0x8, N=1, Z=0.
- **Wraparound:** nop at PC=15 → next `imem_addr`=0.
- **Reset mid-operation:** assert `rst` during a MEM wait → `dmem_req`=0 next cycle, state=FETCH, a late `dmem_ack` ignored, registers 0.
